// File: rtl/stream_output_holder.sv
// rtl/stream_output_holder.sv - ciphertext output FIFO between cipher core and consumer
// Holds core output words until the consumer acknowledges them; flush empties it.
module stream_output_holder #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              flush,
   input  logic              output_acknowledge,
   output logic              output_is_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CW-1:0]     count,
   output logic              overflow,
   output logic              ack_error
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              ack_error_q, ack_error_d;
   logic              push, pop;

   assign in_ready        = (count_q != CW'(DEPTH));
   assign output_is_ready = (count_q != '0);
   assign out_data        = output_is_ready ? mem_q[rd_ptr_q] : '0;
   assign count           = count_q;
   assign overflow        = overflow_q;
   assign ack_error       = ack_error_q;

   assign push = in_valid & in_ready;
   assign pop  = output_acknowledge & output_is_ready;

   always_comb begin
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      ack_error_d = ack_error_q;
      // flush wins over any concurrent push or pop
      if (flush) begin
         rd_ptr_d    = '0;
         wr_ptr_d    = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         ack_error_d = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
         if (in_valid && !in_ready)                  overflow_d  = 1'b1;
         if (output_acknowledge && !output_is_ready) ack_error_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         ack_error_q <= 1'b0;
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         ack_error_q <= ack_error_d;
      end
   end

   always_ff @(posedge clk) begin
      if (nrst && push && !flush) mem_q[wr_ptr_q] <= in_data;
   end

endmodule
